seg7_time_display: RTL and testbench

- Multiplexed 4-digit seven-segment driver that consumes the BCD digit bus produced by the timekeeping counters (H1/H2/M1/M2/S1/S2).
- Shows HH:MM or MM:SS, scans one digit at a time, and blinks the colon at a fixed rate.
- Blanks the field currently being adjusted on the blink phase.
- Sits between the time/alarm datapath and the board's common-anode display pins.

---
 rtl/seg7_time_display.sv | 179 +++++++++++++++++
 tb/tb_seg7_time_display.sv | 128 ++++++++++++
 2 files changed

// File: rtl/seg7_time_display.sv
// Purpose : multiplexed 4-digit common-anode seven-segment driver for the HH:MM / MM:SS time field.
// Latency : anode/seg/dp are registered, one clk behind the internal scan index, snapshot and blink phase.
// Backpress: none; inputs are sampled into a snapshot once per frame and the scan free-runs.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset (everything dark while rst=1)
//   H1,H2,M1,M2,S1,S2   BCD time digits from the timekeeping counters
//   show_secs           0: HH:MM, 1: MM:SS (captured at frame wrap only)
//   blink_h, blink_m    live field-adjust flags; blank that field on the dark blink phase
//   anode [3:0]         active-low digit enables, bit 3 = leftmost digit
//   seg [6:0]           active-low {g,f,e,d,c,b,a}
//   dp                  active-low colon, lit on digit 2 during the visible blink phase
module seg7_time_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] H1,
  input  logic [3:0] H2,
  input  logic [2:0] M1,
  input  logic [3:0] M2,
  input  logic [2:0] S1,
  input  logic [3:0] S2,
  input  logic       show_secs,
  input  logic       blink_h,
  input  logic       blink_m,
  output logic [3:0] anode,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [BW-1:0] bcnt;
  logic          phase;

  logic [1:0] snap_h1;
  logic [3:0] snap_h2;
  logic [2:0] snap_m1;
  logic [3:0] snap_m2;
  logic [2:0] snap_s1;
  logic [3:0] snap_s2;
  logic       snap_ss;

  logic       refresh_tick;
  logic       frame_wrap;
  logic [3:0] digit;
  logic       blank_fld;
  logic [3:0] anode_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;

  assign refresh_tick = (cnt == CNT_LAST);
  // Last cycle of digit 3: the snapshot reloads together with idx wrapping to 0,
  // so a whole frame is always drawn from one consistent set of digits.
  assign frame_wrap   = refresh_tick && (idx == 2'd3);

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Digit scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (refresh_tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Blink phase; starts visible so a fresh display is not dark for half a period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == BCNT_LAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

  // Per-frame snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_h1 <= '0;
      snap_h2 <= '0;
      snap_m1 <= '0;
      snap_m2 <= '0;
      snap_s1 <= '0;
      snap_s2 <= '0;
      snap_ss <= 1'b0;
    end else if (frame_wrap) begin
      snap_h1 <= H1;
      snap_h2 <= H2;
      snap_m1 <= M1;
      snap_m2 <= M2;
      snap_s1 <= S1;
      snap_s2 <= S2;
      snap_ss <= show_secs;
    end
  end

  // Digit selection and field blanking
  always_comb begin
    digit = 4'd0;
    if (snap_ss) begin
      case (idx)
        2'd3:    digit = {1'b0, snap_m1};
        2'd2:    digit = snap_m2;
        2'd1:    digit = {1'b0, snap_s1};
        default: digit = snap_s2;
      endcase
    end else begin
      case (idx)
        2'd3:    digit = {2'b00, snap_h1};
        2'd2:    digit = snap_h2;
        2'd1:    digit = {1'b0, snap_m1};
        default: digit = snap_m2;
      endcase
    end
  end

  // idx[1] selects the left pair (digits 3,2). Blink flags are used live so the
  // adjust feedback reacts without waiting for a frame wrap; the layout they map
  // onto follows the snapshotted show_secs so it matches what is on the glass.
  always_comb begin
    blank_fld = 1'b0;
    if (!phase) begin
      blank_fld = (blink_h && !snap_ss && idx[1]) ||
                  (blink_m && (snap_ss ? idx[1] : !idx[1]));
    end
  end

  always_comb begin
    anode_nxt = ~(4'b0001 << idx);
    seg_nxt   = blank_fld ? 7'b1111111 : decode(digit);
    dp_nxt    = !((idx == 2'd2) && phase);
  end

  // Registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode <= 4'b1111;
      seg   <= 7'b1111111;
      dp    <= 1'b1;
    end else begin
      anode <= anode_nxt;
      seg   <= seg_nxt;
      dp    <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_time_display.sv
module tb_seg7_time_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] H1 = 2'd0;
  logic [3:0] H2 = 4'd0;
  logic [2:0] M1 = 3'd0;
  logic [3:0] M2 = 4'd0;
  logic [2:0] S1 = 3'd0;
  logic [3:0] S2 = 4'd0;
  logic       show_secs = 1'b0;
  logic       blink_h = 1'b0;
  logic       blink_m = 1'b0;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp;

  int e      = 0;  // posedges since reset release
  int total  = 0;
  int passed = 0;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  seg7_time_display #(.REFRESH_DIV(4), .BLINK_DIV(64)) dut (
    .clk(clk), .rst(rst),
    .H1(H1), .H2(H2), .M1(M1), .M2(M2), .S1(S1), .S2(S2),
    .show_secs(show_secs), .blink_h(blink_h), .blink_m(blink_m),
    .anode(anode), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Advance to just after posedge number t
  task automatic go(input int t);
    while (e < t) begin
      @(posedge clk);
      e = e + 1;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    total = total + 1;
    assert ({anode, seg, dp} === {ea, es, ed}) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s: got anode=%b seg=%b dp=%b, expected anode=%b seg=%b dp=%b",
             tag, anode, seg, dp, ea, es, ed);
    end
  endtask

  initial begin
    // Inputs present before the first wrap; frame 0 must still show 00:00
    H1 = 2'd1; H2 = 4'd2; M1 = 3'd3; M2 = 4'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dark", 4'b1111, BL, 1'b1);
    rst = 1'b0;
    e   = 0;

    // Frame 0: scan order and colon
    go(1);  chk("f0_idx0",      4'b1110, D0, 1'b1);
    go(5);  chk("f0_idx1",      4'b1101, D0, 1'b1);
    go(9);  chk("f0_idx2_colon", 4'b1011, D0, 1'b0);
    go(12); chk("f0_idx2_hold", 4'b1011, D0, 1'b0);
    go(13); chk("f0_idx3",      4'b0111, D0, 1'b1);

    // Frame 1: 12:34
    go(17); chk("f1_idx0_m2", 4'b1110, D4, 1'b1);
    go(21); chk("f1_idx1_m1", 4'b1101, D3, 1'b1);
    go(25); chk("f1_idx2_h2", 4'b1011, D2, 1'b0);
    go(29); chk("f1_idx3_h1", 4'b0111, D1, 1'b1);

    // Mid-frame change of M2 does not tear the current frame
    go(33); chk("f2_idx0_m2", 4'b1110, D4, 1'b1);
    M2 = 4'd5;
    go(35); chk("f2_idx0_tearfree", 4'b1110, D4, 1'b1);
    go(49); chk("f3_idx0_m2new", 4'b1110, D5, 1'b1);

    // show_secs captured only at wrap
    show_secs = 1'b1; S1 = 3'd5; S2 = 4'd9;
    go(61); chk("f3_idx3_still_hh", 4'b0111, D1, 1'b1);
    // Frame 4: MM:SS = 35:59, blink phase now dark -> no colon
    go(65); chk("f4_idx0_s2",      4'b1110, D9, 1'b1);
    go(69); chk("f4_idx1_s1",      4'b1101, D5, 1'b1);
    go(73); chk("f4_idx2_nocolon", 4'b1011, D5, 1'b1);
    go(77); chk("f4_idx3_m1",      4'b0111, D3, 1'b1);

    // blink_m live: minutes are the left pair in MM:SS mode
    show_secs = 1'b0; blink_m = 1'b1;
    go(80); chk("f4_idx3_live_blank", 4'b0111, BL, 1'b1);
    // Frame 5: HH:MM, phase dark, minutes blanked
    go(81); chk("f5_idx0_blank", 4'b1110, BL, 1'b1);
    go(85); chk("f5_idx1_blank", 4'b1101, BL, 1'b1);
    go(89); chk("f5_idx2_h2",    4'b1011, D2, 1'b1);
    go(93); chk("f5_idx3_h1",    4'b0111, D1, 1'b1);
    // Frame 8: phase visible again, everything shown
    go(129); chk("f8_idx0_m2",    4'b1110, D5, 1'b0 | 1'b1);
    go(133); chk("f8_idx1_m1",    4'b1101, D3, 1'b1);
    go(137); chk("f8_idx2_colon", 4'b1011, D2, 1'b0);

    // blink_h on the next dark phase
    blink_m = 1'b0; blink_h = 1'b1;
    go(193); chk("f12_idx0_m2",     4'b1110, D5, 1'b1);
    go(201); chk("f12_idx2_hblank", 4'b1011, BL, 1'b1);

    // Reset mid-scan at idx=2
    rst = 1'b1;
    #1;
    chk("midrst_dark", 4'b1111, BL, 1'b1);
    go(202); chk("midrst_dark_clk", 4'b1111, BL, 1'b1);
    rst = 1'b0; blink_h = 1'b0;
    go(203); chk("rst_resume_idx0", 4'b1110, D0, 1'b1);
    go(207); chk("rst_resume_idx1", 4'b1101, D0, 1'b1);
    go(211); chk("rst_resume_idx2", 4'b1011, D0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
